// File: rtl/midi_note_parser.sv
// MIDI byte-stream parser: tracks running status and turns channel voice messages on CHANNEL
// into a last-note-priority NOTE/VELOCITY/GATE interface with a Note On strobe.
module midi_note_parser #(
   parameter logic [3:0] CHANNEL = 4'd0
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [7:0] RX_DATA,
   input  logic       RX_VALID,
   output logic [7:0] NOTE,
   output logic [6:0] VELOCITY,
   output logic       GATE,
   output logic       NOTE_STROBE
);

   typedef enum logic [1:0] {
      StIdle,
      StWaitD1,
      StWaitD2
   } state_e;

   state_e     state_q;
   logic [7:0] status_q;
   logic [6:0] d1_q;
   logic [7:0] note_q;
   logic [6:0] vel_q;
   logic       gate_q;
   logic       strobe_q;

   logic       is_realtime;
   logic       is_syscommon;
   logic       is_status;
   logic       one_byte_msg;
   logic       our_channel;
   logic [3:0] msg_type;

   assign is_realtime  = RX_DATA[7:3] == 5'b11111;
   assign is_syscommon = RX_DATA[7:3] == 5'b11110;
   assign is_status    = RX_DATA[7];
   assign msg_type     = status_q[7:4];
   assign one_byte_msg = (msg_type == 4'hC) || (msg_type == 4'hD);
   assign our_channel  = status_q[3:0] == CHANNEL;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q  <= StIdle;
         status_q <= 8'd0;
         d1_q     <= 7'd0;
         note_q   <= 8'd0;
         vel_q    <= 7'd0;
         gate_q   <= 1'b0;
         strobe_q <= 1'b0;
      end else begin
         strobe_q <= 1'b0;
         if (RX_VALID && !is_realtime) begin
            if (is_syscommon) begin
               state_q  <= StIdle;
               status_q <= 8'd0;
            end else if (is_status) begin
               state_q  <= StWaitD1;
               status_q <= RX_DATA;
            end else begin
               unique case (state_q)
                  StIdle: ;
                  // One-byte messages (program change, aftertouch) never affect the voice.
                  StWaitD1: begin
                     if (!one_byte_msg) begin
                        d1_q    <= RX_DATA[6:0];
                        state_q <= StWaitD2;
                     end
                  end
                  StWaitD2: begin
                     state_q <= StWaitD1;
                     if (our_channel) begin
                        if (msg_type == 4'h9 && RX_DATA[6:0] != 7'd0) begin
                           note_q   <= {1'b0, d1_q};
                           vel_q    <= RX_DATA[6:0];
                           gate_q   <= 1'b1;
                           strobe_q <= 1'b1;
                        end else if (msg_type == 4'h8 || msg_type == 4'h9) begin
                           if (gate_q && d1_q == note_q[6:0]) begin
                              gate_q <= 1'b0;
                           end
                        end else if (msg_type == 4'hB && (d1_q == 7'd123 || d1_q == 7'd120)) begin
                           gate_q <= 1'b0;
                        end
                     end
                  end
                  default: state_q <= StIdle;
               endcase
            end
         end
      end
   end

   assign NOTE        = note_q;
   assign VELOCITY    = vel_q;
   assign GATE        = gate_q;
   assign NOTE_STROBE = strobe_q;

endmodule
